zero_pad_ctrl: RTL and testbench
================================

ZERO_PAD_CTRL -- requirements
Module: zero_pad_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: sample width in bits.
REQ-002 Parameter LEN_W, default 16: width of the frame-length setting.
REQ-003 Parameter DEFAULT_LEN, default 32: frame length after reset.
REQ-004 Parameter SR_FRAME_LEN, default 0: settings-bus address of the frame-length register.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 set_stb  in  1; set_addr  in  8; set_data  in  32: settings-bus write strobe, address, data.
REQ-008 i_tdata  in  WIDTH; i_tlast  in  1; i_tvalid  in  1; i_tready  out  1: input AXI-Stream.
REQ-009 o_tdata  out  WIDTH; o_tlast  out  1; o_tvalid  out  1; o_tready  in  1: output AXI-Stream.
REQ-010 busy  out  1: high while in PAD or DROP state.

Function
REQ-011 Block SHALL turn each input packet into exactly one output frame of active_len samples: pass input, zero-pad short packets, truncate long ones.
REQ-012 States SHALL be PASS, PAD, DROP; a sample counter cnt (LEN_W bits) SHALL count output handshakes within the current frame.
REQ-013 PASS: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready; zero-cycle combinational latency.
REQ-014 PASS, handshake, cnt==active_len-1: o_tlast=1, cnt->0; with i_tlast=1 stay PASS, else go DROP.
REQ-015 PASS, handshake, cnt<active_len-1, i_tlast=1: o_tlast=0, cnt+1, go PAD.
REQ-016 PASS, handshake, neither condition: o_tlast=0, cnt+1.
REQ-017 PAD: o_tdata=0, o_tvalid=1, i_tready=0; cnt+1 per o_tready; at cnt==active_len-1 assert o_tlast, cnt->0, go PASS.
REQ-018 DROP: i_tready=1, o_tvalid=0; discard input; on i_tvalid&i_tlast go PASS.
REQ-019 o_tlast SHALL be high only on the final sample of a frame; o_tdata/o_tlast SHALL stay stable while o_tvalid&!o_tready.
REQ-020 Write with set_stb=1 and set_addr==SR_FRAME_LEN SHALL load set_data[LEN_W-1:0] into shadow_len next cycle.
REQ-021 active_len SHALL load from shadow_len only at a frame boundary (cnt==0 and no frame in progress); mid-frame writes SHALL not alter the current frame.
REQ-022 shadow_len value 0 SHALL be treated as 1; length 1 makes every output sample carry o_tlast.
REQ-023 Simultaneous setting write and frame-end: the new value SHALL apply to the next frame.
REQ-024 cnt SHALL never wrap; maximum frame 2^LEN_W-1 samples.

Reset
REQ-025 On reset assertion, asynchronously: state=PASS, cnt=0, shadow_len=active_len=DEFAULT_LEN.
REQ-026 While reset high: o_tvalid=0, i_tready=0, o_tlast=0, busy=0; a frame in progress SHALL be abandoned without tlast.
REQ-027 After reset release, first input sample SHALL start a new frame.

Configuration
REQ-028 Macro ZERO_PAD_CTRL_STATS_EN defined: ports stat_frames out 32 and stat_truncs out 32 SHALL exist, counting completed frames and DROP entries, reset to 0, wrapping at 2^32.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 len=8, 8-sample packet with tlast on 8th, o_tready=1 -> 8 outputs = input, o_tlast on 8th only, no padding.
REQ-031 len=8, 3-sample packet -> 3 data then 5 zeros, o_tlast on 8th, i_tready=0 for 5 cycles, busy=1 during pad.
REQ-032 len=4, 10-sample packet -> 4 outputs with o_tlast on 4th, 6 samples dropped (i_tready=1, o_tvalid=0), stat_truncs=1 if enabled.
REQ-033 Write len=16 after 2nd sample of len=8 frame -> current frame 8 samples, next frame 16.
REQ-034 o_tready toggling 1-0-1 during PAD with len=5, 1-sample packet -> exactly 4 zeros, o_tdata/o_tlast stable while stalled.
REQ-035 Assert reset mid-PAD -> o_tvalid=0 immediately, cnt=0, next packet produces full DEFAULT_LEN frame.

Source files
------------

// File: rtl/zero_pad_ctrl.sv
// Frame-length normaliser: passes, zero-pads or truncates AXI-Stream packets to active_len samples.
// Optional statistics ports/counters are built when ZERO_PAD_CTRL_STATS_EN is defined.
module zero_pad_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned DEFAULT_LEN  = 32,
    parameter int unsigned SR_FRAME_LEN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy
`ifdef ZERO_PAD_CTRL_STATS_EN
    ,
    output logic [31:0]      stat_frames,
    output logic [31:0]      stat_truncs
`endif
);

    typedef enum logic [1:0] {
        StPass = 2'd0,
        StPad  = 2'd1,
        StDrop = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] DefLen = LEN_W'(DEFAULT_LEN);
    localparam logic [7:0]       SrAddr = 8'(SR_FRAME_LEN);
    localparam logic [LEN_W-1:0] One    = LEN_W'(1);

    state_t           r_state;
    state_t           w_state_d;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_d;
    logic [LEN_W-1:0] r_shadow_len;
    logic [LEN_W-1:0] r_active_len;
    logic             r_len_locked;
    logic [LEN_W-1:0] w_shadow_eff;
    logic [LEN_W-1:0] w_len;
    logic             w_at_last;
    logic             w_frame_done;
    logic             w_frame_start;
    logic             w_unused_set;

    assign w_unused_set = ^set_data;

    assign w_shadow_eff = (r_shadow_len == '0) ? One : r_shadow_len;

    // Before the first sample of a frame is seen the pending setting applies directly, so a
    // write landing on the previous frame's last beat still takes effect for this frame.
    assign w_len = (r_state == StPass && r_cnt == '0 && !r_len_locked) ? w_shadow_eff
                                                                        : r_active_len;
    assign w_at_last     = (r_cnt == (w_len - One));
    assign w_frame_start = (r_state == StPass) && (r_cnt == '0) && i_tvalid && !r_len_locked;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_frame_done = 1'b0;
        o_tdata      = '0;
        o_tvalid     = 1'b0;
        o_tlast      = 1'b0;
        i_tready     = 1'b0;
        busy         = 1'b0;

        unique case (r_state)
            StPass: begin
                o_tdata  = i_tdata;
                o_tvalid = i_tvalid;
                o_tlast  = w_at_last;
                i_tready = o_tready;
                if (i_tvalid && o_tready) begin
                    if (w_at_last) begin
                        w_cnt_d      = '0;
                        w_frame_done = 1'b1;
                        if (!i_tlast) begin
                            w_state_d = StDrop;
                        end
                    end else begin
                        w_cnt_d = r_cnt + One;
                        if (i_tlast) begin
                            w_state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                busy     = 1'b1;
                o_tvalid = 1'b1;
                o_tlast  = w_at_last;
                if (o_tready) begin
                    if (w_at_last) begin
                        w_cnt_d      = '0;
                        w_frame_done = 1'b1;
                        w_state_d    = StPass;
                    end else begin
                        w_cnt_d = r_cnt + One;
                    end
                end
            end
            StDrop: begin
                busy     = 1'b1;
                i_tready = 1'b1;
                if (i_tvalid && i_tlast) begin
                    w_state_d = StPass;
                end
            end
            default: begin
                w_state_d = StPass;
                w_cnt_d   = '0;
            end
        endcase

        // Handshake outputs are forced idle for the whole reset interval.
        if (reset) begin
            o_tvalid = 1'b0;
            o_tlast  = 1'b0;
            i_tready = 1'b0;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StPass;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow_len <= DefLen;
        end else if (set_stb && set_addr == SrAddr) begin
            r_shadow_len <= set_data[LEN_W-1:0];
        end
    end

    // The length is captured once the first sample is presented, keeping o_tlast stable
    // across a stalled first beat and immune to later writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active_len <= DefLen;
            r_len_locked <= 1'b0;
        end else if (w_frame_done) begin
            r_len_locked <= 1'b0;
        end else if (w_frame_start) begin
            r_active_len <= w_shadow_eff;
            r_len_locked <= 1'b1;
        end
    end

`ifdef ZERO_PAD_CTRL_STATS_EN
    logic w_drop_enter;

    assign w_drop_enter = (r_state == StPass) && (w_state_d == StDrop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_truncs <= '0;
        end else begin
            if (w_frame_done) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if (w_drop_enter) begin
                stat_truncs <= stat_truncs + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_zero_pad_ctrl.sv
// Scoreboard bench for zero_pad_ctrl: expected frames are queued per packet and
// compared beat by beat on the output stream.
module tb_zero_pad_ctrl;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned DEFAULT_LEN = 32;

    logic             clk;
    logic             reset;
    logic             set_stb;
    logic [7:0]       set_addr;
    logic [31:0]      set_data;
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic             busy;
`ifdef ZERO_PAD_CTRL_STATS_EN
    logic [31:0]      stat_frames;
    logic [31:0]      stat_truncs;
`endif

    zero_pad_ctrl #(
        .WIDTH        (WIDTH),
        .LEN_W        (LEN_W),
        .DEFAULT_LEN  (DEFAULT_LEN),
        .SR_FRAME_LEN (0)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .busy     (busy)
`ifdef ZERO_PAD_CTRL_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_truncs (stat_truncs)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;
    int model_len = DEFAULT_LEN;
    int busy_cnt = 0;
    int trdy_low_cnt = 0;
    int rdy_mode = 0;
    logic [WIDTH:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // o_tready source: 0 = always ready, 1 = random, 2 = toggle each cycle.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       o_tready = 1'($urandom_range(0, 1));
                2:       o_tready = ~o_tready;
                default: o_tready = 1'b1;
            endcase
        end
    end

    // Output monitor: compares every presented beat with the queue head; pops on handshake.
    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (busy) busy_cnt++;
                if (!i_tready) trdy_low_cnt++;
                if (o_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check_val("spurious_valid", 64'(o_tvalid), 64'd0);
                    end else begin
                        e = exp_q[0];
                        check_val("tdata", 64'(o_tdata), 64'(e[WIDTH-1:0]));
                        check_val("tlast", 64'(o_tlast), 64'(e[WIDTH]));
                        if (o_tready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic write_len(input int v);
        set_stb  = 1'b1;
        set_addr = 8'd0;
        set_data = 32'(v);
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        model_len = (v == 0) ? 1 : v;
    endtask

    // Sends an n-sample packet; optionally issues a length write alongside sample wr_at.
    task automatic send_pkt(input int n, input int base, input int wr_at, input int wr_val);
        int cyc;
        for (int j = 0; j < model_len; j++) begin
            exp_q.push_back({(j == model_len - 1), (j < n) ? WIDTH'(base + j) : WIDTH'(0)});
        end
        for (int i = 0; i < n; i++) begin
            i_tdata  = WIDTH'(base + i);
            i_tlast  = (i == n - 1);
            i_tvalid = 1'b1;
            if (i == wr_at) begin
                set_stb  = 1'b1;
                set_addr = 8'd0;
                set_data = 32'(wr_val);
                model_len = (wr_val == 0) ? 1 : wr_val;
            end
            cyc = 0;
            forever begin
                @(negedge clk);
                if (i_tready) break;
                cyc++;
                if (cyc > 300) begin
                    check_val("in_handshake_timeout", 64'd0, 64'd1);
                    break;
                end
            end
            @(posedge clk);
            #1;
            set_stb = 1'b0;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check_val("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        int t0;
`ifdef ZERO_PAD_CTRL_STATS_EN
        logic [31:0] s0;
`endif
        reset    = 1'b1;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b1;
        #12;
        check_val("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        check_val("rst_i_tready", 64'(i_tready), 64'd0);
        check_val("rst_o_tlast", 64'(o_tlast), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
`ifdef ZERO_PAD_CTRL_STATS_EN
        check_val("rst_stat_frames", 64'(stat_frames), 64'd0);
        check_val("rst_stat_truncs", 64'(stat_truncs), 64'd0);
`endif
        i_tvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Default length after reset: 5 data + 27 zeros.
        send_pkt(5, 32'h100, -1, 0);
        wait_drain();

        // Exact-length packet: no padding, never busy.
        write_len(8);
        b0 = busy_cnt;
        send_pkt(8, 32'h200, -1, 0);
        wait_drain();
        check_val("exact_busy_cycles", 64'(busy_cnt - b0), 64'd0);

        // Short packet: 5 pad beats with input held off.
        b0 = busy_cnt;
        t0 = trdy_low_cnt;
        send_pkt(3, 32'h300, -1, 0);
        wait_drain();
        check_val("pad_busy_cycles", 64'(busy_cnt - b0), 64'd5);
        check_val("pad_tready_low", 64'(trdy_low_cnt - t0), 64'd5);

        // Long packet: 6 samples dropped.
        write_len(4);
        b0 = busy_cnt;
`ifdef ZERO_PAD_CTRL_STATS_EN
        s0 = stat_truncs;
`endif
        send_pkt(10, 32'h400, -1, 0);
        wait_drain();
        check_val("drop_busy_cycles", 64'(busy_cnt - b0), 64'd6);
`ifdef ZERO_PAD_CTRL_STATS_EN
        check_val("stat_truncs_inc", 64'(stat_truncs - s0), 64'd1);
`endif

        // Mid-frame write affects only the following frame.
        write_len(8);
        send_pkt(8, 32'h500, 2, 16);
        send_pkt(16, 32'h600, -1, 0);
        send_pkt(3, 32'h700, -1, 0);
        wait_drain();

        // Write coinciding with the frame's last beat.
        write_len(4);
        send_pkt(4, 32'h800, 3, 6);
        send_pkt(2, 32'h900, -1, 0);
        wait_drain();

        // Zero length behaves as one.
        write_len(0);
        send_pkt(3, 32'hA00, -1, 0);
        send_pkt(1, 32'hA10, -1, 0);
        send_pkt(2, 32'hA20, -1, 0);
        wait_drain();

        // Stalls during padding: 1 data + 4 zeros, outputs held while stalled.
        write_len(5);
        rdy_mode = 2;
        send_pkt(1, 32'hB00, -1, 0);
        wait_drain();
        rdy_mode = 1;

        for (int p = 0; p < 8; p++) begin
            write_len($urandom_range(1, 12));
            send_pkt($urandom_range(1, 15), 32'h1000 * (p + 1), -1, 0);
        end
        wait_drain();
        rdy_mode = 0;

        // Reset in the middle of padding abandons the frame.
        write_len(8);
        send_pkt(1, 32'hC00, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("midpad_rst_o_tvalid", 64'(o_tvalid), 64'd0);
        check_val("midpad_rst_busy", 64'(busy), 64'd0);
        check_val("midpad_rst_i_tready", 64'(i_tready), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_len = DEFAULT_LEN;
        @(posedge clk);
        #1;
        send_pkt(2, 32'hD00, -1, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
